// File: rtl/jelly_stepper_motor_microstep_multi.sv
// Multi-channel microstep phase generator for two-phase bipolar steppers.
// A shared PWM counter blends adjacent full steps and idle channels drop to reduced hold current.
module jelly_stepper_motor_microstep_multi #(
    parameter int NUM_CH          = 2,
    parameter int X_WIDTH         = 32,
    parameter int MICROSTEP_WIDTH = 8,
    parameter int HOLD_WIDTH      = 16,
    parameter int HOLD_DUTY       = 128
) (
    input  logic                        reset_n,
    input  logic                        clk,
    input  logic [NUM_CH-1:0]           enable,
    input  logic                        microstep_en,
    input  logic [HOLD_WIDTH-1:0]       hold_periods,
    input  logic [NUM_CH*X_WIDTH-1:0]   in_x,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           stm_ap_en,
    output logic [NUM_CH-1:0]           stm_an_en,
    output logic [NUM_CH-1:0]           stm_bp_en,
    output logic [NUM_CH-1:0]           stm_bn_en,
    output logic [NUM_CH-1:0]           stm_ap_hl,
    output logic [NUM_CH-1:0]           stm_an_hl,
    output logic [NUM_CH-1:0]           stm_bp_hl,
    output logic [NUM_CH-1:0]           stm_bn_hl,
    output logic                        period_start,
    output logic [NUM_CH-1:0]           hold_active
);

    localparam int M = MICROSTEP_WIDTH;
    localparam logic [M-1:0]          CNT_MAX  = {M{1'b1}};
    localparam logic [M-1:0]          CNT_ONE  = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M:0]            DUTY_CMP = (M+1)'(HOLD_DUTY);
    localparam logic [HOLD_WIDTH-1:0] IDLE_ONE = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    logic [M-1:0] cnt_r;
    logic         period_start_r;
    logic         boundary_s;

    assign boundary_s   = (cnt_r == CNT_MAX);
    assign period_start = period_start_r;

    // Shared free-running PWM counter and period-start marker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r          <= {M{1'b0}};
            period_start_r <= 1'b0;
        end else begin
            cnt_r          <= cnt_r + CNT_ONE;
            period_start_r <= boundary_s;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [X_WIDTH-1:0]    pend_r;
        logic [X_WIDTH-1:0]    act_r;
        logic [HOLD_WIDTH-1:0] idle_r;
        logic [HOLD_WIDTH-1:0] idle_next_s;
        logic [1:0]            phase_s;
        logic [M-1:0]          frac_s;
        logic [1:0]            step_s;
        logic                  hold_s;
        logic                  duty_s;
        logic                  a_pos_s;
        logic                  b_pos_s;
        logic                  en_r;
        logic [3:0]            hl_r;
        logic                  hold_r;

        // Step selection, coil polarity, hold detection and next idle count
        always_comb begin
            phase_s = act_r[M+1:M];
            frac_s  = act_r[M-1:0];
            if (microstep_en && (cnt_r < frac_s)) begin
                step_s = phase_s + 2'd1;
            end else begin
                step_s = phase_s;
            end
            hold_s = (hold_periods != {HOLD_WIDTH{1'b0}}) && (idle_r == hold_periods);
            if (hold_s) begin
                duty_s = ({1'b0, cnt_r} < DUTY_CMP);
            end else begin
                duty_s = 1'b1;
            end
            case (step_s)
                2'd0:    begin a_pos_s = 1'b1; b_pos_s = 1'b1; end
                2'd1:    begin a_pos_s = 1'b0; b_pos_s = 1'b1; end
                2'd2:    begin a_pos_s = 1'b0; b_pos_s = 1'b0; end
                2'd3:    begin a_pos_s = 1'b1; b_pos_s = 1'b0; end
                default: begin a_pos_s = 1'b1; b_pos_s = 1'b1; end
            endcase
            // Idle only advances on a boundary; saturating also clamps a lowered limit
            if (!enable[c]) begin
                idle_next_s = {HOLD_WIDTH{1'b0}};
            end else if (!boundary_s) begin
                idle_next_s = idle_r;
            end else if (pend_r != act_r) begin
                idle_next_s = {HOLD_WIDTH{1'b0}};
            end else if (idle_r < hold_periods) begin
                idle_next_s = idle_r + IDLE_ONE;
            end else begin
                idle_next_s = hold_periods;
            end
        end

        // Double-buffered position capture and idle tracking
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pend_r <= {X_WIDTH{1'b0}};
                act_r  <= {X_WIDTH{1'b0}};
                idle_r <= {HOLD_WIDTH{1'b0}};
            end else begin
                if (in_valid[c]) begin
                    pend_r <= in_x[c*X_WIDTH +: X_WIDTH];
                end
                if (boundary_s) begin
                    act_r <= pend_r;
                end
                idle_r <= idle_next_s;
            end
        end

        // Registered half-bridge drive and hold flag
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                en_r   <= 1'b0;
                hl_r   <= 4'b0000;
                hold_r <= 1'b0;
            end else begin
                hold_r <= hold_s;
                if (enable[c]) begin
                    en_r <= duty_s;
                    hl_r <= {a_pos_s, ~a_pos_s, b_pos_s, ~b_pos_s};
                end else begin
                    en_r <= 1'b0;
                    hl_r <= 4'b0000;
                end
            end
        end

        assign stm_ap_en[c]   = en_r;
        assign stm_an_en[c]   = en_r;
        assign stm_bp_en[c]   = en_r;
        assign stm_bn_en[c]   = en_r;
        assign stm_ap_hl[c]   = hl_r[3];
        assign stm_an_hl[c]   = hl_r[2];
        assign stm_bp_hl[c]   = hl_r[1];
        assign stm_bn_hl[c]   = hl_r[0];
        assign hold_active[c] = hold_r;
    end

endmodule

// File: tb/tb_jelly_stepper_motor_microstep_multi.sv
// Bench for the multi-channel stepper phase generator: vector table, corner sequences,
// and randomized traffic compared each cycle against an arithmetic reference model.
module tb_jelly_stepper_motor_microstep_multi;

    localparam int NCH = 2;
    localparam int XW  = 32;
    localparam int PER = 256;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      enable = 2'b00;
    logic            microstep_en = 1'b0;
    logic [15:0]     hold_periods = 16'd0;
    logic [63:0]     in_x = 64'd0;
    logic [1:0]      in_valid = 2'b00;
    logic [1:0]      stm_ap_en, stm_an_en, stm_bp_en, stm_bn_en;
    logic [1:0]      stm_ap_hl, stm_an_hl, stm_bp_hl, stm_bn_hl;
    logic            period_start;
    logic [1:0]      hold_active;

    jelly_stepper_motor_microstep_multi #(
        .NUM_CH(2), .X_WIDTH(32), .MICROSTEP_WIDTH(8), .HOLD_WIDTH(16), .HOLD_DUTY(128)
    ) dut (
        .reset_n(reset_n), .clk(clk), .enable(enable), .microstep_en(microstep_en),
        .hold_periods(hold_periods), .in_x(in_x), .in_valid(in_valid),
        .stm_ap_en(stm_ap_en), .stm_an_en(stm_an_en), .stm_bp_en(stm_bp_en), .stm_bn_en(stm_bn_en),
        .stm_ap_hl(stm_ap_hl), .stm_an_hl(stm_an_hl), .stm_bp_hl(stm_bp_hl), .stm_bn_hl(stm_bn_hl),
        .period_start(period_start), .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Coil pattern {ap,an,bp,bn} for each full step of the two-phase-on sequence
    logic [3:0] pat [4];

    function automatic logic [3:0] hl_of(input int c);
        return {stm_ap_hl[c], stm_an_hl[c], stm_bp_hl[c], stm_bn_hl[c]};
    endfunction

    function automatic logic [3:0] en_of(input int c);
        return {stm_ap_en[c], stm_an_en[c], stm_bp_en[c], stm_bn_en[c]};
    endfunction

    // Reference model: position arithmetic per clock, expected outputs one clock later
    int         m_cnt;
    logic [31:0] m_pend [2];
    logic [31:0] m_act  [2];
    int         m_idle [2];
    logic [3:0] e_hl [2];
    logic [3:0] e_en [2];
    logic       e_ps;
    logic [1:0] e_hold;
    longint     m_x;
    int         m_ph, m_fr, m_st, m_hp;
    bit         m_hold;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0;
            e_ps  = 1'b0;
            e_hold = 2'b00;
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 32'd0; m_act[c] = 32'd0; m_idle[c] = 0;
                e_hl[c] = 4'h0; e_en[c] = 4'h0;
            end
        end else begin
            m_hp = int'(hold_periods);
            for (int c = 0; c < NCH; c++) begin
                m_x  = longint'(m_act[c]);
                m_ph = int'((m_x / PER) % 4);
                m_fr = int'(m_x % PER);
                m_st = (m_ph + ((microstep_en && (m_cnt < m_fr)) ? 1 : 0)) % 4;
                m_hold = (m_hp != 0) && (m_idle[c] == m_hp);
                e_hl[c] = enable[c] ? pat[m_st] : 4'h0;
                e_en[c] = (enable[c] && (!m_hold || m_cnt < 128)) ? 4'hf : 4'h0;
                e_hold[c] = m_hold;
            end
            e_ps = (m_cnt == PER - 1);
            for (int c = 0; c < NCH; c++) begin
                if (m_cnt == PER - 1) begin
                    if (!enable[c] || m_pend[c] != m_act[c]) m_idle[c] = 0;
                    else m_idle[c] = (m_idle[c] + 1 > m_hp) ? m_hp : m_idle[c] + 1;
                    m_act[c] = m_pend[c];
                end else if (!enable[c]) begin
                    m_idle[c] = 0;
                end
                if (in_valid[c]) m_pend[c] = in_x[c*XW +: XW];
            end
            m_cnt = (m_cnt + 1) % PER;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({hl_of(0), hl_of(1), en_of(0), en_of(1), period_start, hold_active} !==
                {e_hl[0], e_hl[1], e_en[0], e_en[1], e_ps, e_hold}) begin
                errors++;
                $display("FAIL model t=%0t got hl=%h/%h en=%h/%h ps=%b hold=%b want hl=%h/%h en=%h/%h ps=%b hold=%b",
                         $time, hl_of(0), hl_of(1), en_of(0), en_of(1), period_start, hold_active,
                         e_hl[0], e_hl[1], e_en[0], e_en[1], e_ps, e_hold);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) chk("wait_timeout", 32'(m_cnt), 32'(target));
    endtask

    // Leaves the bench at the first output cycle of the next period
    task automatic next_period();
        wait_cnt(0);
        tick();
    endtask

    task automatic write(input int c, input logic [31:0] x);
        if (m_cnt == PER - 1) tick();
        in_x[c*XW +: XW] = x;
        in_valid[c] = 1'b1;
        tick();
        in_valid[c] = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        bit          ms;
        int          k;
        logic [3:0]  hl;
    } vec_t;

    vec_t vecs [15];
    int   n, en_cnt;

    initial begin
        pat[0] = 4'b1010; pat[1] = 4'b0110; pat[2] = 4'b0101; pat[3] = 4'b1001;
        vecs[0]  = '{32'd0,         1'b0, 128, 4'b1010};
        vecs[1]  = '{32'd256,       1'b0, 128, 4'b0110};
        vecs[2]  = '{32'd512,       1'b0, 128, 4'b0101};
        vecs[3]  = '{32'd768,       1'b0, 128, 4'b1001};
        vecs[4]  = '{32'd1024,      1'b0, 128, 4'b1010};
        vecs[5]  = '{32'd64,        1'b1, 0,   4'b0110};
        vecs[6]  = '{32'd64,        1'b1, 63,  4'b0110};
        vecs[7]  = '{32'd64,        1'b1, 64,  4'b1010};
        vecs[8]  = '{32'd64,        1'b1, 255, 4'b1010};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b1, 0,   4'b1010};
        vecs[10] = '{32'hFFFF_FFFF, 1'b1, 254, 4'b1010};
        vecs[11] = '{32'hFFFF_FFFF, 1'b1, 255, 4'b1001};
        vecs[12] = '{32'hFFFF_FFFF, 1'b0, 10,  4'b1001};
        vecs[13] = '{32'd960,       1'b1, 191, 4'b1010};
        vecs[14] = '{32'd960,       1'b1, 192, 4'b1001};

        // Reset with strobes active
        enable = 2'b11;
        in_valid = 2'b11;
        in_x = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (10) tick();
        chk("reset_outputs", 32'({stm_ap_en, stm_an_en, stm_bp_en, stm_bn_en, stm_ap_hl, stm_an_hl,
                                  stm_bp_hl, stm_bn_hl, period_start, hold_active}), 32'd0);
        in_valid = 2'b00;
        in_x = 64'd0;
        reset_n = 1'b1;
        n = 0;
        while (!period_start && n < 1000) begin
            tick();
            n++;
        end
        chk("first_period_start", 32'(n), 32'd256);

        // Vector table on channel 0, channel 1 parked at step 2
        write(1, 32'd512);
        for (int i = 0; i < 15; i++) begin
            microstep_en = vecs[i].ms;
            write(0, vecs[i].x);
            next_period();
            wait_cnt((vecs[i].k + 1) % PER);
            chk($sformatf("vec%0d_hl", i), 32'(hl_of(0)), 32'(vecs[i].hl));
            chk($sformatf("vec%0d_en", i), 32'(en_of(0)), 32'hf);
        end

        // Blend duty: x=64 gives 64 cycles of step 1 per period
        microstep_en = 1'b1;
        write(0, 32'd64);
        next_period();
        en_cnt = 0;
        for (int i = 0; i < PER; i++) begin
            if (hl_of(0) == 4'b0110) en_cnt++;
            tick();
        end
        chk("blend_duty_x64", 32'(en_cnt), 32'd64);

        // Hold entry after three unchanged boundaries, then exit on a new position
        microstep_en = 1'b0;
        hold_periods = 16'd3;
        write(0, 32'h1234);
        next_period();
        chk("hold_b1", 32'(hold_active[0]), 32'd0);
        next_period();
        chk("hold_b2", 32'(hold_active[0]), 32'd0);
        next_period();
        chk("hold_b3", 32'(hold_active[0]), 32'd0);
        next_period();
        chk("hold_b4", 32'(hold_active[0]), 32'd1);
        en_cnt = 0;
        for (int i = 0; i < PER; i++) begin
            if (stm_ap_en[0]) en_cnt++;
            tick();
        end
        chk("hold_duty", 32'(en_cnt), 32'd128);
        chk("hold_hl", 32'(hl_of(0)), 32'b0101);
        write(0, 32'h1300);
        next_period();
        chk("hold_exit", 32'(hold_active[0]), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < PER; i++) begin
            if (stm_ap_en[0]) en_cnt++;
            tick();
        end
        chk("full_duty", 32'(en_cnt), 32'd256);

        // Channel 1 disabled mid-period while in hold, then re-enabled
        chk("ch1_in_hold", 32'(hold_active[1]), 32'd1);
        wait_cnt(100);
        enable[1] = 1'b0;
        tick();
        chk("dis_ch1", 32'({en_of(1), hl_of(1)}), 32'd0);
        chk("ch0_indep", 32'({en_of(0), hl_of(0)}), 32'hf9);
        repeat (5) tick();
        enable[1] = 1'b1;
        tick();
        chk("reen_drive", 32'({en_of(1), hl_of(1)}), 32'hf5);
        next_period();
        chk("reen_idle", 32'(hold_active[1]), 32'd0);

        // Double buffering: last strobe of a period wins, a strobe at cnt 255 lags one period
        hold_periods = 16'd0;
        wait_cnt(100);
        in_x[31:0] = 32'd256; in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0;
        wait_cnt(200);
        in_x[31:0] = 32'd512; in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0;
        chk("dbuf_before", 32'(hl_of(0)), 32'b1001);
        next_period();
        chk("dbuf_a", 32'(hl_of(0)), 32'b0101);
        wait_cnt(129);
        chk("dbuf_b", 32'(hl_of(0)), 32'b0101);
        wait_cnt(PER - 1);
        in_x[31:0] = 32'd768; in_valid[0] = 1'b1; tick(); in_valid[0] = 1'b0;
        tick();
        chk("dbuf_late_a", 32'(hl_of(0)), 32'b0101);
        next_period();
        chk("dbuf_late_b", 32'(hl_of(0)), 32'b1001);

        // Randomized traffic against the model
        for (int i = 0; i < 8000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                in_valid[c] = ($urandom_range(0, 699) == 0);
                if (in_valid[c]) in_x[c*XW +: XW] = $urandom;
            end
            if ($urandom_range(0, 599) == 0) begin
                n = $urandom_range(0, 1);
                enable[n] = ~enable[n];
            end
            if ($urandom_range(0, 999) == 0) microstep_en = ~microstep_en;
            if ($urandom_range(0, 799) == 0) hold_periods = 16'($urandom_range(0, 3));
            tick();
        end
        in_valid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
